// File: rtl/enemy_fire_scheduler.sv
// enemy_fire_scheduler: frame-paced round-robin choice of the next enemy column to fire, limited by free bullet slots.
module enemy_fire_scheduler #(
  parameter int num_cols_p = 8,
  parameter int fire_period_p = 60,
  parameter int max_bullets_p = 2,
  localparam int cw = $clog2(num_cols_p),
  localparam int fw = $clog2(max_bullets_p + 1),
  localparam int pw = $clog2(fire_period_p + 1)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  frame_i,
  input  logic                  game_en_i,
  input  logic [num_cols_p-1:0] col_alive_i,
  input  logic                  bullet_done_i,
  output logic [num_cols_p-1:0] fire_o,
  output logic                  fire_v_o,
  output logic [cw-1:0]         fire_col_o,
  output logic [fw-1:0]         in_flight_o
);
  typedef enum logic [1:0] {IDLE, COOLDOWN, ARB, FIRE} state_t;
  state_t state, state_n;
  logic [pw-1:0] cnt, cnt_n;
  logic [cw-1:0] ptr, ptr_n, grant_q, pick, idx;
  logic [num_cols_p-1:0] fire_n;
  logic [fw-1:0] flight_n;
  logic eligible, hit, last;
  assign eligible = |col_alive_i && in_flight_o < fw'(max_bullets_p);
  assign hit = state == FIRE && col_alive_i[grant_q];
  assign last = frame_i && cnt == pw'(fire_period_p - 1);
  // Descending scan so the column closest to ptr (in wrap order) wins.
  always_comb begin
    pick = ptr;
    idx = '0;
    for (int i = num_cols_p - 1; i >= 0; i--) begin
      idx = cw'((int'(ptr) + i) % num_cols_p);
      if (col_alive_i[idx]) pick = idx;
    end
  end
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    case (state)
      IDLE: begin
        state_n = COOLDOWN;
        cnt_n = '0;
      end
      COOLDOWN: if (frame_i) begin
        state_n = last ? ARB : COOLDOWN;
        cnt_n = last ? '0 : cnt + pw'(1);
      end
      ARB: state_n = eligible ? FIRE : ARB;
      FIRE: state_n = hit ? COOLDOWN : ARB;
    endcase
    if (!game_en_i) begin
      state_n = IDLE;
      cnt_n = '0;
    end
  end
  always_comb begin
    fire_n = hit ? num_cols_p'(1) << grant_q : '0;
    ptr_n = hit ? (grant_q == cw'(num_cols_p - 1) ? '0 : grant_q + 1'b1) : ptr;
    flight_n = hit && bullet_done_i ? in_flight_o :
               hit ? in_flight_o + 1'b1 :
               bullet_done_i && in_flight_o != '0 ? in_flight_o - 1'b1 : in_flight_o;
  end
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      cnt <= '0;
      ptr <= '0;
      grant_q <= '0;
      fire_o <= '0;
      fire_v_o <= 1'b0;
      fire_col_o <= '0;
      in_flight_o <= '0;
    end else begin
      cnt <= cnt_n;
      ptr <= ptr_n;
      grant_q <= state == ARB && eligible ? pick : grant_q;
      fire_o <= fire_n;
      fire_v_o <= hit;
      fire_col_o <= hit ? grant_q : fire_col_o;
      in_flight_o <= flight_n;
    end
endmodule

// File: tb/tb_enemy_fire_scheduler.sv
// tb_enemy_fire_scheduler: random and directed shots against a queue scoreboard fed by a round-robin reference model.
module tb_enemy_fire_scheduler;
  localparam int N = 8, P = 2, M = 2;
  logic clk = 0, reset_i = 1, frame_i = 0, game_en_i = 0, bullet_done_i = 0;
  logic [7:0] col_alive_i = 8'hFF;
  logic [7:0] fire_o;
  logic fire_v_o;
  logic [2:0] fire_col_o;
  logic [1:0] in_flight_o;
  int checks = 0, fails = 0, fires = 0;
  int m_ptr = 0, m_n = 0;
  typedef struct {int col; int n;} exp_t;
  exp_t exp_q[$];

  enemy_fire_scheduler #(.num_cols_p(N), .fire_period_p(P), .max_bullets_p(M)) dut (
    .clk_i(clk), .reset_i(reset_i), .frame_i(frame_i), .game_en_i(game_en_i),
    .col_alive_i(col_alive_i), .bullet_done_i(bullet_done_i), .fire_o(fire_o),
    .fire_v_o(fire_v_o), .fire_col_o(fire_col_o), .in_flight_o(in_flight_o));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset_i && (fire_v_o || fire_o != 0)) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_fire: got col %0d fire %b expected none", fire_col_o, fire_o);
      end else begin
        e = exp_q.pop_front();
        chk("fire_col", int'(fire_col_o), e.col);
        chk("fire_onehot", int'(fire_o), 1 << e.col);
        chk("fire_v", int'(fire_v_o), 1);
        chk("in_flight_at_fire", int'(in_flight_o), e.n);
      end
      fires++;
    end
  end

  function automatic int pick(input logic [7:0] m);
    for (int i = 0; i < N; i++) if (m[(m_ptr + i) % N]) return (m_ptr + i) % N;
    return -1;
  endfunction

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic pulse_frame();
    frame_i = 1;
    tick(1);
    frame_i = 0;
  endtask

  task automatic expect_grant(input int col, input int n);
    exp_q.push_back('{col, n});
    m_n = n;
    m_ptr = (col + 1) % N;
  endtask

  task automatic done();
    bullet_done_i = 1;
    tick(1);
    bullet_done_i = 0;
    if (m_n > 0) m_n--;
    chk("in_flight_after_done", int'(in_flight_o), m_n);
  endtask

  task automatic wait_fires(input int target);
    int t = 0;
    while (fires < target && t < 40) begin
      tick(1);
      t++;
    end
    chk("fire_arrived", int'(fires >= target), 1);
  endtask

  // Starts in COOLDOWN with a zero count; mask holds through ARB, fmask from the FIRE cycle on.
  task automatic shot(input logic [7:0] mask, input bit dfire, input logic [7:0] fmask);
    int first, base;
    base = fires;
    col_alive_i = mask;
    first = pick(mask);
    for (int i = 0; i < P - 1; i++) begin
      pulse_frame();
      tick($urandom_range(0, 2));
    end
    tick(3);
    chk("no_early_fire", fires, base);
    pulse_frame();
    tick(1);
    col_alive_i = fmask;
    bullet_done_i = dfire;
    if (fmask[first]) expect_grant(first, dfire ? m_n : m_n + 1);
    tick(1);
    bullet_done_i = 0;
    if (!fmask[first]) begin
      chk("no_fire_dead_col", int'(fire_v_o), 0);
      if (dfire && m_n > 0) m_n--;
      expect_grant(pick(fmask), m_n + 1);
    end
    wait_fires(base + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    logic [7:0] mask, fmask;
    bit dfire;
    tick(2);
    chk("reset_fire", int'(fire_o), 0);
    chk("reset_fire_v", int'(fire_v_o), 0);
    chk("reset_fire_col", int'(fire_col_o), 0);
    chk("reset_in_flight", int'(in_flight_o), 0);
    reset_i = 0;
    game_en_i = 1;
    tick(2);
    done();
    for (int k = 0; k <= N; k++) begin
      if (m_n > 0) done();
      shot(8'hFF, 0, 8'hFF);
      chk("rr_col", int'(fire_col_o), k % N);
    end
    done();
    shot(8'h10, 0, 8'h10);
    chk("pre_reset_col", int'(fire_col_o), 4);
    col_alive_i = 8'hFF;
    pulse_frame();
    tick(3);
    pulse_frame();
    tick(1);
    #1 reset_i = 1;
    #1;
    chk("async_reset_fire", int'(fire_o), 0);
    chk("async_reset_fire_v", int'(fire_v_o), 0);
    chk("async_reset_fire_col", int'(fire_col_o), 0);
    chk("async_reset_in_flight", int'(in_flight_o), 0);
    tick(1);
    reset_i = 0;
    m_n = 0;
    m_ptr = 0;
    tick(2);
    foreach (exp_q[i]) chk("queue_empty_after_reset", 1, 0);
    for (int k = 0; k < 3; k++) begin
      if (m_n > 0) done();
      shot(8'b1000_0100, 0, 8'b1000_0100);
      chk("skip_dead_col", int'(fire_col_o), k == 1 ? 7 : 2);
    end
    col_alive_i = 8'hFF;
    pulse_frame();
    game_en_i = 0;
    tick(2);
    game_en_i = 1;
    tick(2);
    base = fires;
    pulse_frame();
    tick(4);
    chk("cooldown_cleared_by_disable", fires, base);
    if (m_n >= M) done();
    expect_grant(pick(8'hFF), m_n + 1);
    pulse_frame();
    wait_fires(base + 1);
    while (m_n > 0) done();
    shot(8'hFF, 0, 8'hFF);
    shot(8'hFF, 0, 8'hFF);
    base = fires;
    pulse_frame();
    tick(1);
    pulse_frame();
    tick(6);
    chk("slot_limit_hold", fires, base);
    chk("slot_limit_in_flight", int'(in_flight_o), M);
    expect_grant(pick(8'hFF), M);
    bullet_done_i = 1;
    tick(1);
    bullet_done_i = 0;
    wait_fires(base + 1);
    chk("slot_refill_in_flight", int'(in_flight_o), 2);
    done();
    shot(8'hFF, 1, 8'hFF);
    chk("simultaneous_in_flight", int'(in_flight_o), 1);
    done();
    done();
    chk("done_at_zero", int'(in_flight_o), 0);
    shot(8'h04, 0, 8'h04);
    done();
    shot(8'h18, 0, 8'h10);
    chk("death_race_col", int'(fire_col_o), 4);
    for (int k = 0; k < 30; k++) begin
      mask = 8'($urandom_range(1, 255));
      if (m_n == M || (m_n > 0 && $urandom_range(0, 1) == 1)) done();
      dfire = m_n > 0 && $urandom_range(0, 3) == 0;
      fmask = mask;
      if ($urandom_range(0, 3) == 0) begin
        fmask = mask & ~(8'(1) << pick(mask));
        if (fmask == 0) fmask = mask;
      end
      shot(mask, dfire, fmask);
    end
    tick(5);
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
